// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: credit-limited imem requests, in-order response FIFO, redirect flush.
// Latency: response to id_valid takes 1 cycle, or 0 cycles via bypass when IFU_BYPASS_EN is defined.
// Backpressure: id_ready low fills the FIFO; requests stop once count + outstanding reaches DEPTH.
module ifu_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_inst
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;

  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];
  logic [31:0] pcq_pc    [DEPTH];

  logic        credit_ok, req_fire, rsp_keep, rsp_drop;
  logic        fifo_vld, bypass, push, pop;
  logic [31:0] rsp_pc;

  assign credit_ok      = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && !redirect_valid && credit_ok;
  assign imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep       = imem_rsp_valid && (drop_q == '0);
  assign rsp_pc         = pcq_pc[pcq_rd_q];
  // Outputs are gated during reset because count_q only clears at the reset edge.
  assign fifo_vld       = !rst && (count_q != '0);

`ifdef IFU_BYPASS_EN
  assign bypass = !rst && !redirect_valid && (count_q == '0) && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign id_valid = fifo_vld || bypass;
  assign pop      = fifo_vld && id_ready;
  assign push     = !redirect_valid && rsp_keep && !(bypass && id_ready);

  always_comb begin
    id_pc   = 32'h0;
    id_inst = 32'h0;
    if (bypass) begin
      id_pc   = rsp_pc;
      id_inst = imem_rsp_data;
    end else if (fifo_vld) begin
      id_pc   = fifo_pc[rd_ptr_q];
      id_inst = fifo_inst[rd_ptr_q];
    end
    id_pc_4 = id_pc + 32'd4;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    // The pc queue tracks every in-flight request, dropped or not, so it is never flushed.
    pcq_wr_d      = req_fire ? pcq_wr_q + AW'(1) : pcq_wr_q;
    pcq_rd_d      = imem_rsp_valid ? pcq_rd_q + AW'(1) : pcq_rd_q;
    if (redirect_valid) begin
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(imem_rsp_valid);
      drop_d        = outstanding_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (rsp_drop) drop_d = drop_q - CW'(1);
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pcq_wr_q      <= pcq_wr_d;
      pcq_rd_q      <= pcq_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq_pc[pcq_wr_q] <= imem_req_addr;
    if (push && !rst) begin
      fifo_pc[wr_ptr_q]   <= rsp_pc;
      fifo_inst[wr_ptr_q] <= imem_rsp_data;
    end
  end
endmodule
